// File: rtl/game_ctrl.sv
// Game-flow controller: IDLE/PLAY/DYING/OVER sequencing, BCD score and high
// score, mover enable/reset and the player flash during the dying animation.
module game_ctrl #(
  parameter int unsigned DIE_FRAMES   = 90,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        btn,
  input  logic        collision,
  input  logic        pass,
  output logic        game_en,
  output logic        obj_reset,
  output logic        game_over,
  output logic        flash,
  output logic [1:0]  state,
  output logic [15:0] score,
  output logic [15:0] hiscore
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_DYING = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam logic [7:0] DIE_INIT   = 8'(DIE_FRAMES);
  localparam logic [7:0] FLASH_INIT = 8'(FLASH_FRAMES);

  state_t      state_q, state_d;
  logic        btn_q, btn_d;
  logic        armed_q, armed_d;
  logic [15:0] score_q, score_d;
  logic [15:0] hiscore_q, hiscore_d;
  logic [7:0]  die_cnt_q, die_cnt_d;
  logic [7:0]  flash_cnt_q, flash_cnt_d;
  logic        flash_q, flash_d;
  logic        obj_reset_q, obj_reset_d;
  logic        game_en_q, game_en_d;
  logic        game_over_q, game_over_d;
  logic        btn_edge;

  // BCD increment with per-digit carry; 9999 saturates instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // A button already held when reset releases must be seen low once before
  // any rising edge counts, so armed only sets after a low sample.
  assign btn_edge = btn & ~btn_q & armed_q;

  // Next-state, score/timer updates and registered output values.
  always_comb begin
    state_d     = state_q;
    btn_d       = btn;
    armed_d     = armed_q | ~btn;
    score_d     = score_q;
    hiscore_d   = hiscore_q;
    die_cnt_d   = die_cnt_q;
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    obj_reset_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_edge) begin
          state_d     = S_PLAY;
          score_d     = 16'h0000;
          obj_reset_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (collision && tick) begin
          state_d     = S_DYING;
          die_cnt_d   = DIE_INIT;
          flash_cnt_d = FLASH_INIT;
          flash_d     = 1'b0;
        end else if (pass) begin
          score_d = bcd_inc(score_q);
        end
      end
      S_DYING: begin
        if (tick) begin
          if (die_cnt_q <= 8'd1) begin
            state_d   = S_OVER;
            die_cnt_d = 8'd0;
            flash_d   = 1'b0;
            if (score_q > hiscore_q) begin
              hiscore_d = score_q;
            end
          end else begin
            die_cnt_d = die_cnt_q - 8'd1;
            if (flash_cnt_q <= 8'd1) begin
              flash_d     = ~flash_q;
              flash_cnt_d = FLASH_INIT;
            end else begin
              flash_cnt_d = flash_cnt_q - 8'd1;
            end
          end
        end
      end
      S_OVER: begin
        if (btn_edge) begin
          state_d     = S_IDLE;
          obj_reset_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    game_en_d   = (state_d == S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  // State and datapath registers; reset drops everything including hiscore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      btn_q       <= 1'b0;
      armed_q     <= 1'b0;
      score_q     <= 16'h0000;
      hiscore_q   <= 16'h0000;
      die_cnt_q   <= 8'd0;
      flash_cnt_q <= 8'd0;
      flash_q     <= 1'b0;
      obj_reset_q <= 1'b0;
      game_en_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_d;
      armed_q     <= armed_d;
      score_q     <= score_d;
      hiscore_q   <= hiscore_d;
      die_cnt_q   <= die_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      obj_reset_q <= obj_reset_d;
      game_en_q   <= game_en_d;
      game_over_q <= game_over_d;
    end
  end

  assign state     = state_q;
  assign score     = score_q;
  assign hiscore   = hiscore_q;
  assign flash     = flash_q;
  assign obj_reset = obj_reset_q;
  assign game_en   = game_en_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl built with short dying timers.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        btn = 1'b0;
  logic        collision = 1'b0;
  logic        pass = 1'b0;
  logic        game_en;
  logic        obj_reset;
  logic        game_over;
  logic        flash;
  logic [1:0]  state;
  logic [15:0] score;
  logic [15:0] hiscore;

  int testsRun = 0;
  int testsFailed = 0;

  localparam logic [1:0] IDLE = 2'b00, PLAY = 2'b01, DYING = 2'b10, OVER = 2'b11;

  game_ctrl #(.DIE_FRAMES(6), .FLASH_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn), .collision(collision),
    .pass(pass), .game_en(game_en), .obj_reset(obj_reset), .game_over(game_over),
    .flash(flash), .state(state), .score(score), .hiscore(hiscore)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  typedef struct {
    logic        b, c, p, t;
    logic [1:0]  expState;
    logic        expEn, expObjr;
    logic [15:0] expScore;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, and sample 1 unit after the edge.
  task automatic applyStimulus(input logic b, input logic c, input logic p, input logic t);
    btn = b; collision = c; pass = p; tick = t;
    @(posedge clk);
    #1;
    collision = 1'b0; pass = 1'b0; tick = 1'b0;
  endtask

  // Full game from IDLE: n passes, crash, six dying ticks, back to IDLE.
  task automatic runGame(input int n, input logic [15:0] expScore, input logic [15:0] expHi);
    applyStimulus(1, 0, 0, 0);
    checkOutput("game_start_state", 16'(state), 16'(PLAY));
    checkOutput("game_start_objr", 16'(obj_reset), 16'd1);
    checkOutput("game_start_score", score, 16'h0000);
    applyStimulus(0, 0, 0, 0);
    repeat (n) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("game_dying", 16'(state), 16'(DYING));
    repeat (6) applyStimulus(0, 0, 0, 1);
    checkOutput("game_over_state", 16'(state), 16'(OVER));
    checkOutput("game_over_flag", 16'(game_over), 16'd1);
    checkOutput("game_over_score", score, expScore);
    checkOutput("game_over_hiscore", hiscore, expHi);
    applyStimulus(1, 0, 0, 0);
    checkOutput("game_back_idle", 16'(state), 16'(IDLE));
    checkOutput("game_back_objr", 16'(obj_reset), 16'd1);
    checkOutput("game_idle_score_held", score, expScore);
    applyStimulus(0, 0, 0, 0);
  endtask

  initial begin
    // btn held through reset: no PLAY until it drops and rises again.
    vecs[0] = '{1, 0, 0, 0, IDLE, 0, 0, 16'h0000};
    vecs[1] = '{1, 0, 0, 0, IDLE, 0, 0, 16'h0000};
    vecs[2] = '{0, 0, 0, 0, IDLE, 0, 0, 16'h0000};
    vecs[3] = '{1, 0, 0, 0, PLAY, 1, 1, 16'h0000};
    vecs[4] = '{1, 0, 0, 0, PLAY, 1, 0, 16'h0000};
    vecs[5] = '{0, 0, 1, 0, PLAY, 1, 0, 16'h0001};
    vecs[6] = '{1, 0, 0, 0, PLAY, 1, 0, 16'h0001};
    vecs[7] = '{0, 0, 1, 1, PLAY, 1, 0, 16'h0002};

    btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 16'(state), 16'(IDLE));
    checkOutput("reset_outputs", 16'({game_en, obj_reset, game_over, flash}), 16'd0);
    checkOutput("reset_score", score, 16'h0000);
    checkOutput("reset_hiscore", hiscore, 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].b, vecs[i].c, vecs[i].p, vecs[i].t);
      checkOutput($sformatf("vec%0d_state", i), 16'(state), 16'(vecs[i].expState));
      checkOutput($sformatf("vec%0d_en", i), 16'(game_en), 16'(vecs[i].expEn));
      checkOutput($sformatf("vec%0d_objr", i), 16'(obj_reset), 16'(vecs[i].expObjr));
      checkOutput($sformatf("vec%0d_score", i), score, vecs[i].expScore);
    end

    // Game A: reach 12, then 30, then crash with a coincident pass.
    repeat (10) applyStimulus(0, 0, 1, 0);
    checkOutput("score_12", score, 16'h0012);
    repeat (18) applyStimulus(0, 0, 1, 0);
    checkOutput("score_30", score, 16'h0030);
    applyStimulus(0, 1, 0, 0);
    checkOutput("collision_no_tick", 16'(state), 16'(PLAY));
    applyStimulus(0, 1, 1, 1);
    checkOutput("collision_tick_state", 16'(state), 16'(DYING));
    checkOutput("collision_pass_dropped", score, 16'h0030);
    checkOutput("dying_en", 16'(game_en), 16'd0);

    // Dying animation with a spare non-tick cycle between ticks; btn/pass ignored.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 0, 1, 0);
      applyStimulus((k == 1), 0, 1, 1);
      checkOutput($sformatf("dying_t%0d_flash", k), 16'(flash), 16'((k == 2) || (k == 3)));
      checkOutput($sformatf("dying_t%0d_state", k), 16'(state), 16'((k == 6) ? OVER : DYING));
    end
    checkOutput("over_score", score, 16'h0030);
    checkOutput("over_hiscore", hiscore, 16'h0030);
    checkOutput("over_flag", 16'(game_over), 16'd1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("over_to_idle", 16'(state), 16'(IDLE));
    checkOutput("over_to_idle_objr", 16'(obj_reset), 16'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("objr_one_cycle", 16'(obj_reset), 16'd0);
    applyStimulus(0, 0, 0, 0);

    runGame(42, 16'h0042, 16'h0042);
    runGame(10, 16'h0010, 16'h0042);

    // Saturation at 9999.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    repeat (9998) applyStimulus(0, 0, 1, 0);
    checkOutput("score_9998", score, 16'h9998);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput($sformatf("score_sat%0d", k), score, 16'h9999);
    end
    applyStimulus(0, 1, 0, 1);
    repeat (6) applyStimulus(0, 0, 0, 1);
    checkOutput("sat_hiscore", hiscore, 16'h9999);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Reset asserted mid-DYING takes effect without a clock edge.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("pre_reset_dying", 16'(state), 16'(DYING));
    rst_n = 1'b0;
    #2;
    checkOutput("async_reset_state", 16'(state), 16'(IDLE));
    checkOutput("async_reset_score", score, 16'h0000);
    checkOutput("async_reset_hiscore", hiscore, 16'h0000);
    checkOutput("async_reset_outputs", 16'({game_en, obj_reset, game_over, flash}), 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
